// File: rtl/mem_line_responder_if.sv
// Whole-line request / response channel between the cache controller (master)
// and the backing-memory responder (slave).
interface mem_line_responder_if #(
    parameter int LINE_W = 512,
    parameter int ADDR_W = 13
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [LINE_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_write;
    logic [LINE_W-1:0] rsp_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_write, rsp_rdata
    );
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_write, rsp_rdata
    );
endinterface

// File: rtl/mem_line_responder.sv
// Backing-memory responder: 8K x 512-bit line store, one outstanding line
// request, fixed-latency commit, valid/ready response with saturating counters.

module mem_line_responder_lane #(
    parameter int VEC_W    = 32,
    parameter int ADDR_W   = 13,
    parameter int DEPTH    = 8192,
    parameter int LANE_IDX = 0
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [VEC_W-1:0]  wdata,
    output logic [VEC_W-1:0]  rdata
);
    // Lane 0 stores data ^ addr so zero power-up content reads back as Mem[i] = i.
    logic [VEC_W-1:0] mem_q [DEPTH];
    logic [VEC_W-1:0] bias;

    assign bias  = (LANE_IDX == 0) ? VEC_W'(addr) : '0;
    assign rdata = mem_q[addr] ^ bias;

    always_ff @(posedge clk) begin
        if (we) mem_q[addr] <= wdata ^ bias;
    end
endmodule

module mem_line_responder #(
    parameter int LINE_W  = 512,
    parameter int ADDR_W  = 13,
    parameter int DEPTH   = 8192,
    parameter int LATENCY = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_line_responder_if.slave  bus,
    output logic [15:0]          rd_count,
    output logic [15:0]          wr_count
);
    localparam int         VEC_W     = 32;
    localparam int         NUM_LANES = LINE_W / VEC_W;
    localparam logic [7:0] CNT_LOAD  = 8'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] wdata;
    } req_t;

    state_e                          state_q, state_d;
    req_t                            req_q, req_d;
    logic [7:0]                      cnt_q, cnt_d;
    logic                            rsp_valid_q, rsp_valid_d;
    logic                            rsp_write_q, rsp_write_d;
    logic [LINE_W-1:0]               rsp_rdata_q, rsp_rdata_d;
    logic [15:0]                     rd_count_q, rd_count_d;
    logic [15:0]                     wr_count_q, wr_count_d;
    logic                            accept, commit, mem_we;
    logic [NUM_LANES-1:0][VEC_W-1:0] mem_wdata, mem_rdata;

    assign accept    = (state_q == IDLE) && bus.req_valid;
    assign commit    = (state_q == WAIT) && (cnt_q == '0);
    assign mem_we    = commit && req_q.write;
    assign mem_wdata = req_q.wdata;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        mem_line_responder_lane #(
            .VEC_W   (VEC_W),
            .ADDR_W  (ADDR_W),
            .DEPTH   (DEPTH),
            .LANE_IDX(g)
        ) u_lane (
            .clk  (clk),
            .we   (mem_we),
            .addr (req_q.addr),
            .wdata(mem_wdata[g]),
            .rdata(mem_rdata[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_q       <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rd_count_q  <= '0;
            wr_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            rd_count_q  <= rd_count_d;
            wr_count_q  <= wr_count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.req_valid) state_d = WAIT;
            WAIT:    if (cnt_q == '0) state_d = RESP;
            RESP:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_d       = req_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        rd_count_d  = rd_count_q;
        wr_count_d  = wr_count_q;
        if (accept) begin
            req_d.write = bus.req_write;
            req_d.addr  = bus.req_addr;
            req_d.wdata = bus.req_wdata;
            cnt_d       = CNT_LOAD;
        end
        if ((state_q == WAIT) && (cnt_q != '0)) cnt_d = cnt_q - 8'd1;
        // Read sees the array before this edge's write; a write returns its own data.
        if (commit) begin
            rsp_valid_d = 1'b1;
            rsp_write_d = req_q.write;
            rsp_rdata_d = req_q.write ? req_q.wdata : mem_rdata;
            if (req_q.write) begin
                if (wr_count_q != 16'hFFFF) wr_count_d = wr_count_q + 16'd1;
            end else begin
                if (rd_count_q != 16'hFFFF) rd_count_d = rd_count_q + 16'd1;
            end
        end
        if ((state_q == RESP) && bus.rsp_ready) rsp_valid_d = 1'b0;
    end

    always_comb begin
        bus.req_ready = (state_q == IDLE);
        bus.rsp_valid = rsp_valid_q;
        bus.rsp_write = rsp_write_q;
        bus.rsp_rdata = rsp_rdata_q;
        rd_count      = rd_count_q;
        wr_count      = wr_count_q;
    end
endmodule

// File: tb/tb_mem_line_responder.sv
// Bench for mem_line_responder: two instances (LATENCY 4 and 1) checked against
// an associative-array memory model with saturating request counters.
module tb_mem_line_responder;
    localparam int LINE_W = 512;
    localparam int ADDR_W = 13;
    localparam int DEPTH  = 8192;
    localparam int LAT0   = 4;
    localparam int LAT1   = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] rd_cnt0, wr_cnt0, rd_cnt1, wr_cnt1;
    int          n_chk = 0;
    int          n_fail = 0;

    logic [LINE_W-1:0] mdl0 [int];
    logic [LINE_W-1:0] mdl1 [int];
    int                mrd [2];
    int                mwr [2];

    always #5 clk = ~clk;

    mem_line_responder_if #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) bus0 ();
    mem_line_responder_if #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) bus1 ();

    mem_line_responder #(.LINE_W(LINE_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .LATENCY(LAT0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0), .rd_count(rd_cnt0), .wr_count(wr_cnt0));
    mem_line_responder #(.LINE_W(LINE_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .LATENCY(LAT1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .rd_count(rd_cnt1), .wr_count(wr_cnt1));

    // ---------------- reference model ----------------
    function automatic logic [LINE_W-1:0] m_read(input int s, input int a);
        logic [LINE_W-1:0] v;
        v = LINE_W'(a);
        if (s == 0 && mdl0.exists(a)) v = mdl0[a];
        if (s == 1 && mdl1.exists(a)) v = mdl1[a];
        return v;
    endfunction

    task automatic m_commit(input int s, input bit w, input int a, input logic [LINE_W-1:0] d,
                            output logic [LINE_W-1:0] exp);
        if (w) begin
            if (s == 0) mdl0[a] = d; else mdl1[a] = d;
            if (mwr[s] < 65535) mwr[s]++;
            exp = d;
        end else begin
            if (mrd[s] < 65535) mrd[s]++;
            exp = m_read(s, a);
        end
    endtask

    task automatic m_reset();
        mrd[0] = 0; mrd[1] = 0; mwr[0] = 0; mwr[1] = 0;
    endtask

    // ---------------- pin helpers ----------------
    function automatic logic get_rdy(input int s);  return s != 0 ? bus1.req_ready : bus0.req_ready; endfunction
    function automatic logic get_rv(input int s);   return s != 0 ? bus1.rsp_valid : bus0.rsp_valid; endfunction
    function automatic logic get_rw(input int s);   return s != 0 ? bus1.rsp_write : bus0.rsp_write; endfunction
    function automatic logic [LINE_W-1:0] get_rdata(input int s);
        return s != 0 ? bus1.rsp_rdata : bus0.rsp_rdata;
    endfunction
    function automatic logic [15:0] get_rdc(input int s); return s != 0 ? rd_cnt1 : rd_cnt0; endfunction
    function automatic logic [15:0] get_wrc(input int s); return s != 0 ? wr_cnt1 : wr_cnt0; endfunction

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] r;
        for (int i = 0; i < LINE_W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic set_req(input int s, input logic v, input logic w, input int a, input logic [LINE_W-1:0] d);
        if (s != 0) begin
            bus1.req_valid = v; bus1.req_write = w; bus1.req_addr = ADDR_W'(a); bus1.req_wdata = d;
        end else begin
            bus0.req_valid = v; bus0.req_write = w; bus0.req_addr = ADDR_W'(a); bus0.req_wdata = d;
        end
    endtask

    task automatic set_rr(input int s, input logic r);
        if (s != 0) bus1.rsp_ready = r; else bus0.rsp_ready = r;
    endtask

    // One request end to end. Request pins are scrambled right after accept.
    task automatic txn(input int s, input bit w, input int a, input logic [LINE_W-1:0] d, input int stall,
                       output int lat, output logic [LINE_W-1:0] rdata, output logic rwr,
                       output bit stable, output bit rdy_low, output bit hs_ok, output time acc_t);
        int n;
        n = 0; lat = -1; stable = 1'b1; rdy_low = 1'b1; hs_ok = 1'b1;
        @(negedge clk);
        set_req(s, 1'b1, w, a, d);
        set_rr(s, stall == 0);
        while (get_rdy(s) !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        @(posedge clk);
        acc_t = $time;
        #1 set_req(s, 1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, DEPTH - 1), rand_line());
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk); #1;
            if (get_rdy(s) !== 1'b0) rdy_low = 1'b0;
            if (get_rv(s) === 1'b1) begin lat = k; break; end
        end
        rdata = get_rdata(s);
        rwr   = get_rw(s);
        repeat (stall) begin
            @(negedge clk);
            if (get_rv(s) !== 1'b1 || get_rdata(s) !== rdata || get_rw(s) !== rwr) stable = 1'b0;
            if (get_rdy(s) !== 1'b0) rdy_low = 1'b0;
        end
        @(negedge clk); set_rr(s, 1'b1);
        @(posedge clk); #1;
        if (get_rv(s) !== 1'b0 || get_rdy(s) !== 1'b1) hs_ok = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        n_chk++; if (bus0.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 1", bus0.req_ready); end
        n_chk++; if (bus0.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", bus0.rsp_valid); end
        n_chk++; if (bus0.rsp_write !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_write: got %b expected 0", bus0.rsp_write); end
        n_chk++; if (bus0.rsp_rdata !== '0) begin n_fail++; $display("FAIL reset_rsp_rdata: got %0h expected 0", bus0.rsp_rdata); end
        n_chk++; if (rd_cnt0 !== 16'd0 || wr_cnt0 !== 16'd0) begin n_fail++; $display("FAIL reset_counts: got %0h/%0h expected 0/0", rd_cnt0, wr_cnt0); end
        n_chk++; if (bus1.req_ready !== 1'b1 || bus1.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dut1: got ready %b valid %b expected 1/0", bus1.req_ready, bus1.rsp_valid); end
    endtask

    task automatic test_fill();
        int lat; logic [LINE_W-1:0] rd, exp; logic rw; bit st, rl, hs; time t;
        txn(0, 1'b0, 8, '0, 0, lat, rd, rw, st, rl, hs, t);
        m_commit(0, 1'b0, 8, '0, exp);
        n_chk++; if (lat !== LAT0) begin n_fail++; $display("FAIL fill_latency: got %0d expected %0d", lat, LAT0); end
        n_chk++; if (rd !== exp) begin n_fail++; $display("FAIL fill_rdata: got %0h expected %0h", rd, exp); end
        n_chk++; if (rw !== 1'b0) begin n_fail++; $display("FAIL fill_rsp_write: got %b expected 0", rw); end
        n_chk++; if (rd_cnt0 !== 16'(mrd[0])) begin n_fail++; $display("FAIL fill_rd_count: got %0d expected %0d", rd_cnt0, mrd[0]); end
        n_chk++; if (!rl || !hs) begin n_fail++; $display("FAIL fill_handshake: got ready_low %b hs %b expected 1/1", rl, hs); end
    endtask

    task automatic test_writeback();
        int lat; logic [LINE_W-1:0] rd, exp; logic rw; bit st, rl, hs; time t;
        txn(0, 1'b1, 8, LINE_W'(129), 0, lat, rd, rw, st, rl, hs, t);
        m_commit(0, 1'b1, 8, LINE_W'(129), exp);
        n_chk++; if (rd !== exp || rw !== 1'b1) begin n_fail++; $display("FAIL wb_write_rsp: got %0h/%b expected %0h/1", rd, rw, exp); end
        txn(0, 1'b0, 8, '0, 0, lat, rd, rw, st, rl, hs, t);
        m_commit(0, 1'b0, 8, '0, exp);
        n_chk++; if (rd !== exp) begin n_fail++; $display("FAIL wb_read_back: got %0h expected %0h", rd, exp); end
        txn(0, 1'b0, 1032, '0, 0, lat, rd, rw, st, rl, hs, t);
        m_commit(0, 1'b0, 1032, '0, exp);
        n_chk++; if (rd !== exp) begin n_fail++; $display("FAIL wb_other_line: got %0h expected %0h", rd, exp); end
        n_chk++; if (wr_cnt0 !== 16'(mwr[0]) || rd_cnt0 !== 16'(mrd[0])) begin n_fail++;
            $display("FAIL wb_counts: got wr %0d rd %0d expected wr %0d rd %0d", wr_cnt0, rd_cnt0, mwr[0], mrd[0]); end
    endtask

    task automatic test_backpressure();
        logic [LINE_W-1:0] exp0, exp1, held; bit rl, st; int k;
        rl = 1'b1; st = 1'b1;
        @(negedge clk); set_req(0, 1'b1, 1'b0, 0, rand_line()); set_rr(0, 1'b0);
        @(posedge clk); #1 set_req(0, 1'b1, 1'b0, 5, rand_line());
        m_commit(0, 1'b0, 0, '0, exp0);
        k = 0;
        while (bus0.rsp_valid !== 1'b1 && k < 50) begin
            if (bus0.req_ready !== 1'b0) rl = 1'b0;
            @(posedge clk); #1; k++;
        end
        held = bus0.rsp_rdata;
        n_chk++; if (held !== exp0) begin n_fail++; $display("FAIL bp_rdata: got %0h expected %0h", held, exp0); end
        repeat (10) begin
            @(negedge clk);
            if (bus0.rsp_valid !== 1'b1 || bus0.rsp_rdata !== held || bus0.rsp_write !== 1'b0) st = 1'b0;
            if (bus0.req_ready !== 1'b0) rl = 1'b0;
        end
        n_chk++; if (!st) begin n_fail++; $display("FAIL bp_stable: got unstable response expected stable"); end
        n_chk++; if (!rl) begin n_fail++; $display("FAIL bp_req_ready: got high while busy expected low"); end
        set_rr(0, 1'b1);
        @(posedge clk); #1;
        n_chk++; if (bus0.req_ready !== 1'b1 || bus0.rsp_valid !== 1'b0) begin n_fail++;
            $display("FAIL bp_after_hs: got ready %b valid %b expected 1/0", bus0.req_ready, bus0.rsp_valid); end
        @(posedge clk); #1;
        n_chk++; if (bus0.req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_second_accept: got ready %b expected 0", bus0.req_ready); end
        set_req(0, 1'b0, 1'b0, 0, '0);
        m_commit(0, 1'b0, 5, '0, exp1);
        k = 0;
        while (bus0.rsp_valid !== 1'b1 && k < 50) begin @(posedge clk); #1; k++; end
        n_chk++; if (bus0.rsp_rdata !== exp1) begin n_fail++; $display("FAIL bp_second_rdata: got %0h expected %0h", bus0.rsp_rdata, exp1); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_wait();
        int lat; logic [LINE_W-1:0] rd, exp; logic rw; bit st, rl, hs; time t;
        @(negedge clk); set_req(0, 1'b1, 1'b1, 1024, LINE_W'(20));
        @(posedge clk); #1 set_req(0, 1'b0, 1'b0, 0, '0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        m_reset();
        n_chk++; if (bus0.req_ready !== 1'b1 || bus0.rsp_valid !== 1'b0 || bus0.rsp_rdata !== '0 || bus0.rsp_write !== 1'b0) begin n_fail++;
            $display("FAIL rst_mid_outputs: got ready %b valid %b write %b expected 1/0/0 data 0", bus0.req_ready, bus0.rsp_valid, bus0.rsp_write); end
        n_chk++; if (rd_cnt0 !== 16'd0 || wr_cnt0 !== 16'd0) begin n_fail++; $display("FAIL rst_mid_counts: got %0d/%0d expected 0/0", rd_cnt0, wr_cnt0); end
        #1 rst_n = 1'b1;
        txn(0, 1'b0, 1024, '0, 0, lat, rd, rw, st, rl, hs, t);
        m_commit(0, 1'b0, 1024, '0, exp);
        n_chk++; if (rd !== exp) begin n_fail++; $display("FAIL rst_mid_no_write: got %0h expected %0h", rd, exp); end
        n_chk++; if (wr_cnt0 !== 16'(mwr[0]) || rd_cnt0 !== 16'(mrd[0])) begin n_fail++;
            $display("FAIL rst_mid_counts_after: got wr %0d rd %0d expected wr %0d rd %0d", wr_cnt0, rd_cnt0, mwr[0], mrd[0]); end
    endtask

    task automatic test_boundary_lat1();
        int lat; logic [LINE_W-1:0] rd, exp; logic rw; bit st, rl, hs; time t1, t2;
        txn(1, 1'b1, DEPTH - 1, LINE_W'(32'hDEAD), 0, lat, rd, rw, st, rl, hs, t1);
        m_commit(1, 1'b1, DEPTH - 1, LINE_W'(32'hDEAD), exp);
        n_chk++; if (lat !== LAT1) begin n_fail++; $display("FAIL lat1_latency: got %0d expected %0d", lat, LAT1); end
        txn(1, 1'b0, DEPTH - 1, '0, 0, lat, rd, rw, st, rl, hs, t2);
        m_commit(1, 1'b0, DEPTH - 1, '0, exp);
        n_chk++; if (rd !== exp) begin n_fail++; $display("FAIL lat1_read_8191: got %0h expected %0h", rd, exp); end
        n_chk++; if (t2 - t1 !== 64'(30)) begin n_fail++; $display("FAIL lat1_spacing: got %0t expected 30", t2 - t1); end
        n_chk++; if (wr_cnt1 !== 16'(mwr[1]) || rd_cnt1 !== 16'(mrd[1])) begin n_fail++;
            $display("FAIL lat1_counts: got wr %0d rd %0d expected wr %0d rd %0d", wr_cnt1, rd_cnt1, mwr[1], mrd[1]); end
    endtask

    task automatic test_random();
        int pool [5] = '{0, 7, 8, 1032, DEPTH - 1};
        int s, a, stall, lat;
        bit w, st, rl, hs;
        logic [LINE_W-1:0] d, rd, exp; logic rw; time t;
        for (int i = 0; i < 40; i++) begin
            s = $urandom_range(0, 1);
            w = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 3) == 0) ? $urandom_range(0, DEPTH - 1) : pool[$urandom_range(0, 4)];
            d = rand_line();
            stall = $urandom_range(0, 3);
            txn(s, w, a, d, stall, lat, rd, rw, st, rl, hs, t);
            m_commit(s, w, a, d, exp);
            n_chk++; if (lat !== (s != 0 ? LAT1 : LAT0)) begin n_fail++; $display("FAIL rnd_latency[%0d]: got %0d expected %0d", i, lat, s != 0 ? LAT1 : LAT0); end
            n_chk++; if (rd !== exp || rw !== w) begin n_fail++; $display("FAIL rnd_rsp[%0d]: got %0h/%b expected %0h/%b", i, rd, rw, exp, w); end
            n_chk++; if (!st || !rl || !hs) begin n_fail++; $display("FAIL rnd_protocol[%0d]: got stable %b ready_low %b hs %b expected 1/1/1", i, st, rl, hs); end
            n_chk++; if (get_rdc(s) !== 16'(mrd[s]) || get_wrc(s) !== 16'(mwr[s])) begin n_fail++;
                $display("FAIL rnd_counts[%0d]: got rd %0d wr %0d expected rd %0d wr %0d", i, get_rdc(s), get_wrc(s), mrd[s], mwr[s]); end
        end
    endtask

    task automatic test_saturation();
        int lat; logic [LINE_W-1:0] rd, exp; logic rw; bit st, rl, hs; time t;
        @(negedge clk);
        force dut0.rd_count_q = 16'hFFFE;
        @(negedge clk);
        release dut0.rd_count_q;
        #1;
        mrd[0] = 65534;
        n_chk++; if (rd_cnt0 !== 16'hFFFE) begin n_fail++; $display("FAIL sat_preload: got %0h expected fffe", rd_cnt0); end
        for (int i = 0; i < 3; i++) begin
            txn(0, 1'b0, i * 3, '0, 0, lat, rd, rw, st, rl, hs, t);
            m_commit(0, 1'b0, i * 3, '0, exp);
            n_chk++; if (rd_cnt0 !== 16'(mrd[0])) begin n_fail++; $display("FAIL sat_step[%0d]: got %0h expected %0h", i, rd_cnt0, mrd[0]); end
        end
        n_chk++; if (rd_cnt0 !== 16'hFFFF) begin n_fail++; $display("FAIL sat_final: got %0h expected ffff", rd_cnt0); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        m_reset();
        set_req(0, 1'b0, 1'b0, 0, '0); set_req(1, 1'b0, 1'b0, 0, '0);
        set_rr(0, 1'b1); set_rr(1, 1'b1);
        #12;
        test_reset();
        @(negedge clk) rst_n = 1'b1;
        test_fill();
        test_writeback();
        test_backpressure();
        test_reset_mid_wait();
        test_boundary_lat1();
        test_random();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
